// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing, RGB332 colours and playfield geometry
// used by the sync generator and the playfield renderer.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int FIELD_COLS = 8;
    localparam int FIELD_ROWS = 20;
    localparam int FIELD_BITS = FIELD_COLS * FIELD_ROWS;

    localparam int FRAME_PX = 4;
    localparam int BAR_GAP  = 8;
    localparam int BAR_H    = 8;

    localparam logic [7:0] RGB_BLACK = 8'b000_000_00;
    localparam logic [7:0] RGB_FILL  = 8'b111_100_00;
    localparam logic [7:0] RGB_EDGE  = 8'b100_010_00;
    localparam logic [7:0] RGB_FRAME = 8'b011_011_11;

    typedef enum logic [2:0] {
        PIX_BLANK,
        PIX_FRAME,
        PIX_CELL,
        PIX_BAR,
        PIX_NONE
    } pix_class_e;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic [7:0] rgb;
    } vga_out_t;

endpackage

// File: rtl/vga_sync_gen.sv
// Pixel-tick divider plus horizontal/vertical counters with raw
// (unregistered) active-low syncs and the visible-area flag.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_VIS   = H_VISIBLE,
    parameter int H_FP    = H_FRONT,
    parameter int H_SW    = H_SYNC,
    parameter int H_BP    = H_BACK,
    parameter int V_VIS   = V_VISIBLE,
    parameter int V_FP    = V_FRONT,
    parameter int V_SW    = V_SYNC,
    parameter int V_BP    = V_BACK
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_hcount,
    output logic [CNT_W-1:0] o_vcount,
    output logic             o_hsync_n,
    output logic             o_vsync_n,
    output logic             o_visible
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam logic [CNT_W-1:0] H_END  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_END  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] HS_LO  = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_HI  = CNT_W'(H_VIS + H_FP + H_SW);
    localparam logic [CNT_W-1:0] VS_LO  = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_HI  = CNT_W'(V_VIS + V_FP + V_SW);

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             w_tick;

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                if (r_h == H_LAST) begin
                    r_h <= '0;
                    r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end
        end
    end

    assign o_tick    = w_tick;
    assign o_hcount  = r_h;
    assign o_vcount  = r_v;
    assign o_hsync_n = !((r_h >= HS_LO) && (r_h < HS_HI));
    assign o_vsync_n = !((r_v >= VS_LO) && (r_v < VS_HI));
    assign o_visible = (r_h < H_END) && (r_v < V_END);

endmodule

// File: rtl/vga_playfield_renderer.sv
// Renders a once-per-frame snapshot of the 8x20 playfield and the low
// score byte onto VGA, with sync and colour registered on the pixel tick.
module vga_playfield_renderer
    import vga_pkg::*;
#(
    parameter int         CLK_DIV     = 2,
    parameter int         CELL_PX     = 16,
    parameter int         X_ORG       = 256,
    parameter int         Y_ORG       = 80,
    parameter logic [7:0] FILL_COLOR  = RGB_FILL,
    parameter logic [7:0] EDGE_COLOR  = RGB_EDGE,
    parameter logic [7:0] FRAME_COLOR = RGB_FRAME,
    parameter int         H_VIS       = H_VISIBLE,
    parameter int         H_FP        = H_FRONT,
    parameter int         H_SW        = H_SYNC,
    parameter int         H_BP        = H_BACK,
    parameter int         V_VIS       = V_VISIBLE,
    parameter int         V_FP        = V_FRONT,
    parameter int         V_SW        = V_SYNC,
    parameter int         V_BP        = V_BACK
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [FIELD_BITS-1:0] blocks,
    input  logic [31:0]           score,
    output logic                  HSync,
    output logic                  VSync,
    output logic [2:0]            vgaRed,
    output logic [2:0]            vgaGreen,
    output logic [1:0]            vgaBlue,
    output logic                  frame_tick
);

    localparam int CELL_SH = $clog2(CELL_PX);
    localparam int FW      = FIELD_COLS * CELL_PX;
    localparam int FH      = FIELD_ROWS * CELL_PX;

    localparam logic [CNT_W-1:0] FX0  = CNT_W'(X_ORG);
    localparam logic [CNT_W-1:0] FX1  = CNT_W'(X_ORG + FW);
    localparam logic [CNT_W-1:0] FY0  = CNT_W'(Y_ORG);
    localparam logic [CNT_W-1:0] FY1  = CNT_W'(Y_ORG + FH);
    localparam logic [CNT_W-1:0] OX0  = CNT_W'((X_ORG >= FRAME_PX) ? X_ORG - FRAME_PX : 0);
    localparam logic [CNT_W-1:0] OX1  = CNT_W'(X_ORG + FW + FRAME_PX);
    localparam logic [CNT_W-1:0] OY0  = CNT_W'((Y_ORG >= FRAME_PX) ? Y_ORG - FRAME_PX : 0);
    localparam logic [CNT_W-1:0] OY1  = CNT_W'(Y_ORG + FH + FRAME_PX);
    localparam logic [CNT_W-1:0] BY0  = CNT_W'(Y_ORG + FH + BAR_GAP);
    localparam logic [CNT_W-1:0] BY1  = CNT_W'(Y_ORG + FH + BAR_GAP + BAR_H);
    localparam logic [CNT_W-1:0] MASK = CNT_W'(CELL_PX - 1);
    localparam logic [CNT_W-1:0] VSNP = CNT_W'(V_VIS);

    logic             w_tick;
    logic [CNT_W-1:0] w_h;
    logic [CNT_W-1:0] w_v;
    logic             w_hs_n;
    logic             w_vs_n;
    logic             w_visible;

    vga_sync_gen #(
        .CLK_DIV (CLK_DIV),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SW    (H_SW),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SW    (V_SW),
        .V_BP    (V_BP)
    ) u_sync (
        .i_clk     (Clk),
        .i_rst_n   (Reset_n),
        .o_tick    (w_tick),
        .o_hcount  (w_h),
        .o_vcount  (w_v),
        .o_hsync_n (w_hs_n),
        .o_vsync_n (w_vs_n),
        .o_visible (w_visible)
    );

    logic [FIELD_BITS-1:0] r_snap;
    logic [7:0]            r_snap_score;
    logic                  r_frame_tick;
    vga_out_t              r_out;

    logic             w_snap_evt;
    logic             w_in_field;
    logic             w_in_outer;
    logic             w_in_bar;
    logic [CNT_W-1:0] w_dx;
    logic [CNT_W-1:0] w_dy;
    logic [CNT_W-1:0] w_ox;
    logic [CNT_W-1:0] w_oy;
    logic [2:0]       w_col;
    logic [4:0]       w_srow;
    logic [4:0]       w_rrow;
    logic [7:0]       w_idx;
    logic             w_cell_edge;
    pix_class_e       w_class;
    logic [7:0]       w_rgb;
    logic             w_unused;

    assign w_unused   = ^score[31:8];
    assign w_snap_evt = w_tick && (w_h == '0) && (w_v == VSNP);

    assign w_in_field = (w_h >= FX0) && (w_h < FX1) && (w_v >= FY0) && (w_v < FY1);
    assign w_in_outer = (w_h >= OX0) && (w_h < OX1) && (w_v >= OY0) && (w_v < OY1);
    assign w_in_bar   = (w_h >= FX0) && (w_h < FX1) && (w_v >= BY0) && (w_v < BY1);

    // Differences wrap outside the field; they only select bits under the range flags.
    assign w_dx        = w_h - FX0;
    assign w_dy        = w_v - FY0;
    assign w_col       = 3'(w_dx >> CELL_SH);
    assign w_srow      = 5'(w_dy >> CELL_SH);
    assign w_rrow      = 5'(FIELD_ROWS - 1) - w_srow;
    assign w_idx       = {w_rrow, w_col};
    assign w_ox        = w_dx & MASK;
    assign w_oy        = w_dy & MASK;
    assign w_cell_edge = (w_ox == '0) || (w_ox == MASK) || (w_oy == '0) || (w_oy == MASK);

    always_comb begin
        w_class = PIX_NONE;
        if (!w_visible) begin
            w_class = PIX_BLANK;
        end else if (w_in_outer && !w_in_field) begin
            w_class = PIX_FRAME;
        end else if (w_in_field) begin
            w_class = PIX_CELL;
        end else if (w_in_bar) begin
            w_class = PIX_BAR;
        end
    end

    // Score bar slots run MSB on the left, so slot k shows bit 7-k (= ~k).
    always_comb begin
        w_rgb = RGB_BLACK;
        unique case (w_class)
            PIX_FRAME: w_rgb = FRAME_COLOR;
            PIX_CELL: begin
                if (r_snap[w_idx]) begin
                    w_rgb = w_cell_edge ? EDGE_COLOR : FILL_COLOR;
                end
            end
            PIX_BAR: begin
                if (r_snap_score[~w_col]) begin
                    w_rgb = FILL_COLOR;
                end
            end
            default: w_rgb = RGB_BLACK;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_snap       <= '0;
            r_snap_score <= '0;
            r_frame_tick <= 1'b0;
            r_out        <= '{hsync: 1'b1, vsync: 1'b1, rgb: RGB_BLACK};
        end else begin
            r_frame_tick <= w_snap_evt;
            if (w_snap_evt) begin
                r_snap       <= blocks;
                r_snap_score <= score[7:0];
            end
            if (w_tick) begin
                r_out <= '{hsync: w_hs_n, vsync: w_vs_n, rgb: w_rgb};
            end
        end
    end

    assign HSync      = r_out.hsync;
    assign VSync      = r_out.vsync;
    assign vgaRed     = r_out.rgb[7:5];
    assign vgaGreen   = r_out.rgb[4:2];
    assign vgaBlue    = r_out.rgb[1:0];
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_playfield_renderer.sv
// Scoreboard bench for vga_playfield_renderer on a shrunken raster so
// several whole frames, snapshots and a mid-frame reset fit in a short run.
module tb_vga_playfield_renderer;

    localparam int CLK_DIV = 2;
    localparam int CELL_PX = 4;
    localparam int X_ORG   = 8;
    localparam int Y_ORG   = 6;
    localparam int H_VIS = 48, H_FP = 4, H_SW = 8, H_BP = 4;
    localparam int V_VIS = 104, V_FP = 3, V_SW = 2, V_BP = 4;
    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
    localparam logic [7:0] FILL  = 8'b111_100_00;
    localparam logic [7:0] EDGE  = 8'b100_010_00;
    localparam logic [7:0] FRAME = 8'b011_011_11;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic [159:0] blocks;
    logic [31:0]  score;
    logic         HSync, VSync, frame_tick;
    logic [2:0]   vgaRed, vgaGreen;
    logic [1:0]   vgaBlue;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    vga_playfield_renderer #(
        .CLK_DIV (CLK_DIV), .CELL_PX (CELL_PX), .X_ORG (X_ORG), .Y_ORG (Y_ORG),
        .FILL_COLOR (FILL), .EDGE_COLOR (EDGE), .FRAME_COLOR (FRAME),
        .H_VIS (H_VIS), .H_FP (H_FP), .H_SW (H_SW), .H_BP (H_BP),
        .V_VIS (V_VIS), .V_FP (V_FP), .V_SW (V_SW), .V_BP (V_BP)
    ) dut (
        .Clk (Clk), .Reset_n (Reset_n), .blocks (blocks), .score (score),
        .HSync (HSync), .VSync (VSync), .vgaRed (vgaRed), .vgaGreen (vgaGreen),
        .vgaBlue (vgaBlue), .frame_tick (frame_tick)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int         h;
        int         v;
        logic       hs;
        logic       vs;
        logic [7:0] rgb;
    } exp_t;

    typedef struct {
        int         ep;
        int         fr;
        int         x;
        int         y;
        logic [7:0] rgb;
    } probe_t;

    exp_t   sb[$];
    probe_t probes[$];

    int           m_div, m_h, m_v, m_frame, m_ticks;
    logic [159:0] m_snap;
    logic [7:0]   m_sscore;
    int           epoch;
    int           o_frame;
    int unsigned  hh_obs, hh_exp;
    int           hs_low;
    int           last_ft;

    function automatic logic [7:0] ref_rgb(int x, int y);
        int fx0, fx1, fy0, fy1, col, srow, idx, ox, oy, b;
        bit in_field, in_outer;
        fx0 = X_ORG;
        fx1 = X_ORG + 8 * CELL_PX;
        fy0 = Y_ORG;
        fy1 = Y_ORG + 20 * CELL_PX;
        if (x >= H_VIS || y >= V_VIS) return 8'h00;
        in_field = x >= fx0 && x < fx1 && y >= fy0 && y < fy1;
        in_outer = x >= fx0 - 4 && x < fx1 + 4 && y >= fy0 - 4 && y < fy1 + 4;
        if (in_outer && !in_field) return FRAME;
        if (in_field) begin
            col  = (x - fx0) / CELL_PX;
            srow = (y - fy0) / CELL_PX;
            idx  = (19 - srow) * 8 + col;
            ox   = (x - fx0) % CELL_PX;
            oy   = (y - fy0) % CELL_PX;
            if (!m_snap[idx]) return 8'h00;
            if (ox == 0 || oy == 0 || ox == CELL_PX - 1 || oy == CELL_PX - 1) return EDGE;
            return FILL;
        end
        if (y >= fy1 + 8 && y <= fy1 + 15 && x >= fx0 && x < fx1) begin
            b = 7 - (x - fx0) / CELL_PX;
            return m_sscore[b] ? FILL : 8'h00;
        end
        return 8'h00;
    endfunction

    always @(posedge Clk) begin
        exp_t e;
        logic ft_exp;
        ft_exp = 1'b0;
        if (!Reset_n) begin
            m_div = 0; m_h = 0; m_v = 0; m_frame = 0; m_ticks = 0;
            m_snap = '0; m_sscore = '0;
            sb.delete();
            o_frame = -1; hh_obs = 0; hh_exp = 0; hs_low = 0; last_ft = -1;
        end else begin
            if (m_div == CLK_DIV - 1) begin
                m_div = 0;
                e.h   = m_h;
                e.v   = m_v;
                e.hs  = !(m_h >= H_VIS + H_FP && m_h < H_VIS + H_FP + H_SW);
                e.vs  = !(m_v >= V_VIS + V_FP && m_v < V_VIS + V_FP + V_SW);
                e.rgb = ref_rgb(m_h, m_v);
                sb.push_back(e);
                if (m_h == 0 && m_v == V_VIS) begin
                    m_snap   = blocks;
                    m_sscore = score[7:0];
                    ft_exp   = 1'b1;
                end
                m_ticks++;
                if (m_h == H_TOT - 1) begin
                    m_h = 0;
                    if (m_v == V_TOT - 1) begin
                        m_v = 0;
                        m_frame++;
                    end else begin
                        m_v++;
                    end
                end else begin
                    m_h++;
                end
            end else begin
                m_div++;
            end
            #1;
            if (frame_tick || ft_exp) begin
                chk("frame_tick", 64'(frame_tick), 64'(ft_exp));
                if (frame_tick) begin
                    if (last_ft >= 0) chk("frame_tick_period", 64'(m_ticks - last_ft), 64'(H_TOT * V_TOT));
                    last_ft = m_ticks;
                end
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.h == 0 && e.v == 0) o_frame++;
                hh_obs = (hh_obs * 33) ^ {22'b0, HSync, VSync, vgaRed, vgaGreen, vgaBlue};
                hh_exp = (hh_exp * 33) ^ {22'b0, e.hs, e.vs, e.rgb};
                if (!HSync) hs_low++;
                foreach (probes[i]) begin
                    if (probes[i].ep == epoch && probes[i].fr == o_frame &&
                        probes[i].x == e.h && probes[i].y == e.v)
                        chk($sformatf("pix_e%0d_f%0d_%0d_%0d", epoch, o_frame, e.h, e.v),
                            64'({vgaRed, vgaGreen, vgaBlue}), 64'(probes[i].rgb));
                end
                if (e.h == H_TOT - 1) begin
                    chk($sformatf("line_e%0d_f%0d_v%0d", epoch, o_frame, e.v), 64'(hh_obs), 64'(hh_exp));
                    chk($sformatf("hs_low_v%0d", e.v), 64'(hs_low), 64'(H_SW));
                    hh_obs = 0; hh_exp = 0; hs_low = 0;
                end
            end
        end
    end

    task automatic add_probe(input int ep, input int fr, input int x, input int y, input logic [7:0] c);
        probe_t p;
        p.ep = ep; p.fr = fr; p.x = x; p.y = y; p.rgb = c;
        probes.push_back(p);
    endtask

    task automatic wait_at(input int fr, input int ln);
        int n;
        n = 0;
        while (!(m_frame == fr && m_v == ln) && n < 40000) begin
            @(posedge Clk);
            #2;
            n++;
        end
        if (n >= 40000) chk("wait_timeout", 64'(n), 64'(0));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_hsync"}, 64'(HSync), 64'(1));
        chk({tag, "_vsync"}, 64'(VSync), 64'(1));
        chk({tag, "_rgb"}, 64'({vgaRed, vgaGreen, vgaBlue}), 64'(0));
        chk({tag, "_ftick"}, 64'(frame_tick), 64'(0));
    endtask

    initial begin
        int n;
        blocks = '0;
        blocks[0] = 1'b1;
        blocks[159] = 1'b1;
        score = 32'h0000_0081;
        epoch = 0;
        add_probe(0, 0, 9, 83, 8'h00);
        add_probe(0, 0, 6, 40, FRAME);
        add_probe(0, 1, 9, 83, FILL);
        add_probe(0, 1, 8, 82, EDGE);
        add_probe(0, 1, 11, 85, EDGE);
        add_probe(0, 1, 12, 83, 8'h00);
        add_probe(0, 1, 37, 7, FILL);
        add_probe(0, 1, 6, 40, FRAME);
        add_probe(0, 1, 42, 40, FRAME);
        add_probe(0, 1, 45, 40, 8'h00);
        add_probe(0, 1, 9, 95, FILL);
        add_probe(0, 1, 37, 95, FILL);
        add_probe(0, 1, 33, 95, 8'h00);
        add_probe(0, 1, 37, 101, FILL);
        add_probe(0, 1, 37, 93, 8'h00);
        add_probe(0, 1, 9, 102, 8'h00);
        add_probe(0, 2, 9, 83, 8'h00);
        add_probe(0, 2, 13, 83, FILL);
        add_probe(1, 0, 9, 7, 8'h00);
        add_probe(1, 0, 37, 7, 8'h00);
        add_probe(1, 0, 6, 7, FRAME);

        repeat (10) @(posedge Clk);
        #1;
        chk_reset_outs("rst");
        @(negedge Clk);
        Reset_n = 1'b1;

        n = 0;
        while (HSync && n < 2000) begin
            @(posedge Clk);
            #2;
            n++;
        end
        chk("first_hs_low_tick", 64'(m_ticks), 64'(H_VIS + H_FP + 1));

        wait_at(1, 40);
        @(negedge Clk);
        blocks = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        blocks[0] = 1'b0;
        blocks[1] = 1'b1;
        score = $urandom();

        wait_at(2, 50);
        @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        blocks = '1;
        score = 32'hFFFF_FFFF;
        epoch = 1;
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        wait_at(0, 20);
        repeat (4) @(posedge Clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
